lcd_ctrl: RTL and testbench



---
 rtl/lcd_ctrl_pkg.sv | 31 +++
 rtl/lcd_timer.sv | 36 +++
 rtl/lcd_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// rtl/lcd_ctrl_pkg.sv - shared types, bit positions and init command table for lcd_ctrl
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_INIT  = 3'd5
  } state_e;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_RW_BIT = 9;
  localparam int LCD_RS_BIT = 8;

  // Power-up sequence: function set 8-bit/2-line, display on, clear, entry mode.
  localparam int INIT_CMDS = 4;
  localparam logic [INIT_CMDS-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x00/0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data[7:1] == 7'b0000000) || (data[7:1] == 7'b0000001));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter that stops at zero and flags it
module lcd_timer #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 write sequencer (setup/EN pulse/hold/exec wait); optional power-up init via LCD_CTRL_INIT_EN
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  input  logic        lcd_on_i,
  output logic        busy_o,
  output logic [31:0] lcd_o
);

`ifdef LCD_CTRL_INIT_EN
  localparam int MAX_CYC = max_int(max_int(max_int(T_SETUP_CYC, T_EN_CYC),
                                           max_int(T_HOLD_CYC, T_CMD_CYC)),
                                   max_int(T_CLR_CYC, T_CLR_CYC * 10));
`else
  localparam int MAX_CYC = max_int(max_int(max_int(T_SETUP_CYC, T_EN_CYC),
                                           max_int(T_HOLD_CYC, T_CMD_CYC)),
                                   T_CLR_CYC);
`endif
  localparam int TW = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP_CYC - 1);
  localparam logic [TW-1:0] LD_EN    = TW'(T_EN_CYC - 1);
  localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD_CYC - 1);
  localparam logic [TW-1:0] LD_CMD   = TW'(T_CMD_CYC - 1);
  localparam logic [TW-1:0] LD_CLR   = TW'(T_CLR_CYC - 1);

`ifdef LCD_CTRL_INIT_EN
  localparam state_e        RESET_STATE = ST_INIT;
  localparam logic [TW-1:0] TIMER_RST   = TW'(T_CLR_CYC * 10 - 1);
`else
  localparam state_e        RESET_STATE = ST_IDLE;
  localparam logic [TW-1:0] TIMER_RST   = '0;
`endif

  state_e        state_q, state_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic [31:0]   lcd_q, lcd_d;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_zero;

`ifdef LCD_CTRL_INIT_EN
  logic       init_active_q, init_active_d;
  logic [1:0] init_idx_q, init_idx_d;
`endif

  lcd_timer #(
    .W         (TW),
    .RESET_VAL (TIMER_RST)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  // Next-state logic: each timed phase advances when the timer has drained.
  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    data_d     = data_q;
    timer_load = 1'b0;
    timer_val  = '0;
`ifdef LCD_CTRL_INIT_EN
    init_active_d = init_active_q;
    init_idx_d    = init_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d    = ST_SETUP;
          rs_d       = req_rs_i;
          data_d     = req_data_i;
          timer_load = 1'b1;
          timer_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (timer_zero) begin
          state_d    = ST_PULSE;
          timer_load = 1'b1;
          timer_val  = LD_EN;
        end
      end
      ST_PULSE: begin
        if (timer_zero) begin
          state_d    = ST_HOLD;
          timer_load = 1'b1;
          timer_val  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          state_d    = ST_WAIT;
          timer_load = 1'b1;
          timer_val  = is_long_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
        end
      end
      ST_WAIT: begin
        if (timer_zero) begin
          state_d = ST_IDLE;
`ifdef LCD_CTRL_INIT_EN
          // During power-up, chain straight into the next table entry.
          if (init_active_q) begin
            if (init_idx_q == 2'(INIT_CMDS - 1)) begin
              init_active_d = 1'b0;
            end else begin
              init_idx_d = init_idx_q + 2'd1;
              state_d    = ST_SETUP;
              rs_d       = 1'b0;
              data_d     = INIT_ROM[init_idx_q + 2'd1];
              timer_load = 1'b1;
              timer_val  = LD_SETUP;
            end
          end
`endif
        end
      end
`ifdef LCD_CTRL_INIT_EN
      ST_INIT: begin
        if (timer_zero) begin
          state_d    = ST_SETUP;
          rs_d       = 1'b0;
          data_d     = INIT_ROM[0];
          timer_load = 1'b1;
          timer_val  = LD_SETUP;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output word follows the next state so it is aligned with the state register.
  always_comb begin
    lcd_d             = '0;
    lcd_d[LCD_ON_BIT] = lcd_on_i;
    lcd_d[LCD_RW_BIT] = 1'b0;
    lcd_d[LCD_RS_BIT] = lcd_q[LCD_RS_BIT];
    lcd_d[7:0]        = lcd_q[7:0];
    if ((state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD)) begin
      lcd_d[LCD_RS_BIT] = rs_d;
      lcd_d[7:0]        = data_d;
    end
    lcd_d[LCD_EN_BIT] = (state_d == ST_PULSE);
  end

  // State, latched request and registered LCD word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      lcd_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      lcd_q   <= lcd_d;
    end
  end

`ifdef LCD_CTRL_INIT_EN
  // Power-up sequence progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      init_active_q <= 1'b1;
      init_idx_q    <= 2'd0;
    end else begin
      init_active_q <= init_active_d;
      init_idx_q    <= init_idx_d;
    end
  end
`endif

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = !req_ready_o;
  assign lcd_o       = lcd_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed self-checking bench for lcd_ctrl
module tb_lcd_ctrl;

  localparam int TS  = 2;
  localparam int TE  = 12;
  localparam int TH  = 2;
  localparam int TC  = 20;
  localparam int TCL = 100;

  // Cycle (counted from the accept edge) on which ready is seen again.
  localparam int RDY_CMD = 37;   // 2 + 12 + 2 + 20 + 1
  localparam int RDY_CLR = 117;  // 2 + 12 + 2 + 100 + 1

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_rs_i;
  logic [7:0]  req_data_i;
  logic        lcd_on_i;
  logic        busy_o;
  logic [31:0] lcd_o;

  int checks   = 0;
  int failures = 0;

  lcd_ctrl #(
    .T_SETUP_CYC (TS),
    .T_EN_CYC    (TE),
    .T_HOLD_CYC  (TH),
    .T_CMD_CYC   (TC),
    .T_CLR_CYC   (TCL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_rs_i    (req_rs_i),
    .req_data_i  (req_data_i),
    .lcd_on_i    (lcd_on_i),
    .busy_o      (busy_o),
    .lcd_o       (lcd_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic en, input logic rs, input logic [7:0] d);
    return {1'b1, 20'b0, en, 1'b0, rs, d};
  endfunction

  // One transfer: accept on the first edge, then check every cycle up to the ready cycle.
  task automatic xfer(input logic rs, input logic [7:0] d, input int rdy, input bit toggle,
                      input logic nv, input logic nrs, input logic [7:0] nd);
    logic en;
    req_valid_i = 1'b1;
    req_rs_i    = rs;
    req_data_i  = d;
    step();
    for (int k = 1; k <= rdy; k++) begin
      en = (k > TS) && (k <= TS + TE);
      check($sformatf("x%02h c%0d lcd", d, k), lcd_o, exp_word(en, rs, d));
      check($sformatf("x%02h c%0d ready", d, k), {31'b0, req_ready_o}, {31'b0, (k == rdy)});
      check($sformatf("x%02h c%0d busy", d, k), {31'b0, busy_o}, {31'b0, (k != rdy)});
      if (toggle && k < rdy) begin
        req_valid_i = 1'($urandom);
        req_rs_i    = 1'($urandom);
        req_data_i  = 8'($urandom);
      end else begin
        req_valid_i = nv;
        req_rs_i    = nrs;
        req_data_i  = nd;
      end
      if (k < rdy) step();
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_rs_i    = 1'b0;
    req_data_i  = 8'h00;
    lcd_on_i    = 1'b1;
    step();
    step();
    check("rst lcd", lcd_o, 32'h0);
    check("rst ready", {31'b0, req_ready_o}, 32'd1);
    check("rst busy", {31'b0, busy_o}, 32'd0);

    rst_i = 1'b0;
    step();
    check("on bit", lcd_o, 32'h8000_0000);
    check("idle ready", {31'b0, req_ready_o}, 32'd1);

    // Data write and command waits, including clear/home boundaries.
    xfer(1'b1, 8'h41, RDY_CMD, 1'b0, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h01, RDY_CLR, 1'b0, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h38, RDY_CMD, 1'b0, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h03, RDY_CLR, 1'b0, 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h04, RDY_CMD, 1'b0, 1'b0, 1'b0, 8'h00);
    xfer(1'b1, 8'h01, RDY_CMD, 1'b0, 1'b0, 1'b0, 8'h00);

    // Valid held high: second byte taken on the first ready cycle.
    xfer(1'b1, 8'h41, RDY_CMD, 1'b0, 1'b1, 1'b1, 8'h42);
    xfer(1'b1, 8'h42, RDY_CMD, 1'b0, 1'b0, 1'b0, 8'h00);

    // Inputs churning while busy must not disturb the latched byte.
    xfer(1'b1, 8'h5A, RDY_CMD, 1'b1, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of the EN pulse.
    req_valid_i = 1'b1;
    req_rs_i    = 1'b1;
    req_data_i  = 8'h99;
    step();
    req_valid_i = 1'b0;
    repeat (4) step();
    check("pulse en", lcd_o, exp_word(1'b1, 1'b1, 8'h99));
    rst_i = 1'b1;
    step();
    check("mid rst lcd", lcd_o, 32'h0);
    check("mid rst ready", {31'b0, req_ready_o}, 32'd1);
    rst_i = 1'b0;
    step();
    check("post rst lcd", lcd_o, 32'h8000_0000);
    check("post rst ready", {31'b0, req_ready_o}, 32'd1);
    xfer(1'b1, 8'h77, RDY_CMD, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
